div8bc2_seq: RTL and testbench
==============================

// Module: div8bc2_seq
// PURPOSE
//  Multi-cycle signed two's-complement divider: inverse companion of the combinational
//  8-bit signed multiplier in the HPS-FPGA arithmetic coprocessor. Computes quotient and
//  remainder of a/b by restoring shift-subtract on magnitudes, one bit per clock.
//  Driven by the coprocessor control FSM through a start/done handshake.
// PARAMETERS
//  DATA_W   8   operand/result width (two's complement); supported range 4..16
// PORTS
//  clk          in   1        system clock; all state updates on rising edge
//  rst_n        in   1        asynchronous active-low reset
//  start        in   1        request; sampled only in IDLE
//  a            in   DATA_W   signed dividend, captured on accepted start
//  b            in   DATA_W   signed divisor, captured on accepted start
//  busy         out  1        high while an operation is in progress (not IDLE)
//  done         out  1        one-cycle pulse: results valid
//  quotient     out  DATA_W   signed quotient, truncated toward zero
//  remainder    out  DATA_W   signed remainder; sign follows dividend, |r| < |b|
//  div_by_zero  out  1        set with done when b == 0
//  overflow     out  1        set with done when true quotient exceeds DATA_W signed range
// BEHAVIOUR
//  - Reset: FSM=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0,
//    overflow=0; internal registers cleared. Reset mid-operation aborts with no done.
//  - States: IDLE -> (start & b!=0) CALC; IDLE -> (start & b==0) FIN; CALC -> FIN after
//    DATA_W iterations; FIN -> IDLE.
//  - IDLE: on start, capture a, b; form |a|, |b| in DATA_W+1 bits (|-2^(W-1)| fits);
//    q_sign = a[W-1]^b[W-1]; r_sign = a[W-1]; clear partial remainder; load bit counter.
//  - CALC (DATA_W cycles): rem = {rem, dividend MSB}; if rem >= |b| then rem -= |b|,
//    shift 1 into quotient, else shift 0. Counter decrements; exit when it reaches 0.
//  - FIN (1 cycle): apply signs (negate quotient if q_sign, remainder if r_sign);
//    register outputs; done=1 for this cycle only; busy=0 from next cycle.
//  - Latency: start accepted at edge N -> done high in cycle following edge N+DATA_W+1;
//    divide-by-zero: done in cycle following edge N+1.
//  - Divide by zero: quotient = all ones (-1), remainder = a, div_by_zero=1, overflow=0.
//  - Overflow: only a = -2^(W-1), b = -1; quotient = -2^(W-1) (wrapped), remainder=0,
//    overflow=1.
//  - Flags and results hold their values after done until the next accepted start;
//    flags are cleared when a new start is accepted.
//  - start while busy (CALC/FIN) is ignored; no queuing. start high in IDLE every cycle
//    re-triggers back-to-back operations, one per DATA_W+2 cycles.
//  - a/b changes after acceptance do not affect the running operation.
//  - Invariant on every done without div_by_zero: a == quotient*b + remainder (mod 2^W).
// TESTING
//  1. a=100, b=7 -> after DATA_W+1 edges done=1, quotient=14, remainder=2, flags 0.
//  2. a=-100, b=7 -> quotient=-14, remainder=-2; a=100, b=-7 -> quotient=-14, rem=2.
//  3. a=-128, b=-1 -> quotient=-128, remainder=0, overflow=1; a=-128, b=1 -> -128, ovf=0.
//  4. a=55, b=0 -> done after 2 edges, quotient=-1, remainder=55, div_by_zero=1.
//  5. start pulsed again mid-CALC with new operands -> ignored; first result unchanged,
//     exactly one done; rst_n low mid-CALC -> all outputs 0, no done, IDLE next.
//  6. Exhaustive 8-bit sweep (b!=0) vs. reference model: truncating division,
//     invariant holds, busy/done timing exact for every pair.

Source files
------------

// File: rtl/div8bc2_seq.sv
// div8bc2_seq: multi-cycle signed divider, restoring shift-subtract on magnitudes, one quotient bit per clock
module div8bc2_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o,
  output logic              div_by_zero_o,
  output logic              overflow_o
);
  localparam int W  = DATA_W;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] ITER = CW'(W);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t        state_q;
  logic [W-1:0]  dvd_q;
  logic [W:0]    dvs_q;
  logic [W:0]    rem_q;
  logic [CW-1:0] cnt_q;
  logic          q_sign_q;
  logic          r_sign_q;
  logic          dz_q;
  logic [W:0]    a_ext;
  logic [W:0]    b_ext;
  logic [W:0]    a_mag;
  logic [W:0]    b_mag;
  logic [W:0]    rem_sh;
  logic          rem_ge;
  logic [W:0]    rem_d;
  logic [W-1:0]  dvd_d;
  logic [W-1:0]  q_res;
  logic [W-1:0]  r_res;
  // Operand magnitudes (W+1 bits so the most negative value fits), one restoring step, and sign fix-up
  always_comb begin
    a_ext  = {a_i[W-1], a_i};
    b_ext  = {b_i[W-1], b_i};
    a_mag  = a_i[W-1] ? -a_ext : a_ext;
    b_mag  = b_i[W-1] ? -b_ext : b_ext;
    rem_sh = {rem_q[W-1:0], dvd_q[W-1]};
    rem_ge = rem_sh >= dvs_q;
    rem_d  = rem_ge ? rem_sh - dvs_q : rem_sh;
    dvd_d  = {dvd_q[W-2:0], rem_ge};
    q_res  = q_sign_q ? -dvd_q : dvd_q;
    r_res  = r_sign_q ? -rem_q[W-1:0] : rem_q[W-1:0];
  end
  // Control FSM with datapath registers and registered outputs; dvd_q holds the raw dividend on divide-by-zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dvd_q         <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      q_sign_q      <= 1'b0;
      r_sign_q      <= 1'b0;
      dz_q          <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            div_by_zero_o <= 1'b0;
            overflow_o    <= 1'b0;
            busy_o        <= 1'b1;
            q_sign_q      <= a_i[W-1] ^ b_i[W-1];
            r_sign_q      <= a_i[W-1];
            rem_q         <= '0;
            cnt_q         <= ITER;
            dvs_q         <= b_mag;
            dz_q          <= b_i == '0;
            dvd_q         <= b_i == '0 ? a_i : a_mag[W-1:0];
            state_q       <= b_i == '0 ? FIN : CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIN;
        end
        FIN: begin
          state_q       <= IDLE;
          busy_o        <= 1'b0;
          done_o        <= 1'b1;
          quotient_o    <= dz_q ? '1 : q_res;
          remainder_o   <= dz_q ? dvd_q : r_res;
          div_by_zero_o <= dz_q;
          overflow_o    <= ~dz_q & ~q_sign_q & dvd_q[W-1];
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div8bc2_seq.sv
// tb_div8bc2_seq: directed and swept checks of the sequential signed divider
module tb_div8bc2_seq;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       dz_o;
  logic       ov_o;
  int total;
  int bad;
  logic [7:0] q;
  logic [7:0] r;
  logic       dz;
  logic       ov;
  logic       bb;
  int         lat;

  div8bc2_seq #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .quotient_o(quotient), .remainder_o(remainder),
    .div_by_zero_o(dz_o), .overflow_o(ov_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation from IDLE and wait (bounded) for done; lat counts edges after the accepting edge, -1 on timeout
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, output logic [7:0] qo, output logic [7:0] ro,
                       output logic dzo, output logic ovo, output int lato, output logic bbo);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lato = -1; bbo = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lato = i;
        if (busy) bbo = 1'b1;
        break;
      end
      if (!busy) bbo = 1'b1;
      @(negedge clk);
    end
    qo = quotient; ro = remainder; dzo = dz_o; ovo = ov_o;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, quotient, remainder, dz_o, ov_o} !== 20'd0) begin
      bad++;
      $display("FAIL reset_state got=%h want=0", {busy, done, quotient, remainder, dz_o, ov_o});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, quotient, remainder, dz_o, ov_o} !== 20'd0) begin
      bad++;
      $display("FAIL post_reset_idle got=%h want=0", {busy, done, quotient, remainder, dz_o, ov_o});
    end
  endtask

  task automatic test_basic;
    do_op(8'd100, 8'd7, q, r, dz, ov, lat, bb);
    total++;
    if ({q, r, dz, ov} !== {8'd14, 8'd2, 2'b00} || lat != 9 || bb) begin
      bad++;
      $display("FAIL pos_pos q=%0d r=%0d dz=%b ov=%b lat=%0d bb=%b want 14 2 0 0 9 0", q, r, dz, ov, lat, bb);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || quotient !== 8'd14 || remainder !== 8'd2) begin
      bad++;
      $display("FAIL done_pulse_hold done=%b q=%0d r=%0d want 0 14 2", done, quotient, remainder);
    end
    do_op(8'h9C, 8'd7, q, r, dz, ov, lat, bb);
    total++;
    if ({q, r, dz, ov} !== {8'hF2, 8'hFE, 2'b00} || lat != 9 || bb) begin
      bad++;
      $display("FAIL neg_pos q=%h r=%h dz=%b ov=%b lat=%0d want f2 fe 0 0 9", q, r, dz, ov, lat);
    end
    do_op(8'd100, 8'hF9, q, r, dz, ov, lat, bb);
    total++;
    if ({q, r, dz, ov} !== {8'hF2, 8'h02, 2'b00} || lat != 9 || bb) begin
      bad++;
      $display("FAIL pos_neg q=%h r=%h dz=%b ov=%b lat=%0d want f2 02 0 0 9", q, r, dz, ov, lat);
    end
    do_op(8'h9C, 8'hF9, q, r, dz, ov, lat, bb);
    total++;
    if ({q, r, dz, ov} !== {8'h0E, 8'hFE, 2'b00} || lat != 9 || bb) begin
      bad++;
      $display("FAIL neg_neg q=%h r=%h lat=%0d want 0e fe 9", q, r, lat);
    end
  endtask

  task automatic test_overflow;
    do_op(8'h80, 8'hFF, q, r, dz, ov, lat, bb);
    total++;
    if ({q, r, dz, ov} !== {8'h80, 8'h00, 2'b01} || lat != 9 || bb) begin
      bad++;
      $display("FAIL ovf_min_m1 q=%h r=%h dz=%b ov=%b lat=%0d want 80 00 0 1 9", q, r, dz, ov, lat);
    end
    do_op(8'h80, 8'h01, q, r, dz, ov, lat, bb);
    total++;
    if ({q, r, dz, ov} !== {8'h80, 8'h00, 2'b00} || lat != 9 || bb) begin
      bad++;
      $display("FAIL min_div_1 q=%h r=%h dz=%b ov=%b want 80 00 0 0", q, r, dz, ov);
    end
  endtask

  task automatic test_div_zero;
    do_op(8'd55, 8'd0, q, r, dz, ov, lat, bb);
    total++;
    if ({q, r, dz, ov} !== {8'hFF, 8'd55, 2'b10} || lat != 1 || bb) begin
      bad++;
      $display("FAIL dz_pos q=%h r=%0d dz=%b ov=%b lat=%0d bb=%b want ff 55 1 0 1 0", q, r, dz, ov, lat, bb);
    end
    do_op(8'hC9, 8'd0, q, r, dz, ov, lat, bb);
    total++;
    if ({q, r, dz, ov} !== {8'hFF, 8'hC9, 2'b10} || lat != 1) begin
      bad++;
      $display("FAIL dz_neg q=%h r=%h dz=%b lat=%0d want ff c9 1 1", q, r, dz, lat);
    end
    @(negedge clk);
    a = 8'd9; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (dz_o !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL dz_clear_on_start dz=%b busy=%b want 0 1", dz_o, busy);
    end
    repeat (12) @(negedge clk);
    total++;
    if (quotient !== 8'd3 || remainder !== 8'd0) begin
      bad++;
      $display("FAIL after_dz q=%0d r=%0d want 3 0", quotient, remainder);
    end
  endtask

  task automatic test_ignore_start;
    int dones;
    dones = 0;
    @(negedge clk);
    a = 8'd100; b = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'd5; b = 8'd1;
    repeat (3) @(negedge clk);
    start = 1'b1; a = 8'd77; b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dones++;
        total++;
        if (quotient !== 8'd14 || remainder !== 8'd2) begin
          bad++;
          $display("FAIL ignore_start_result q=%0d r=%0d want 14 2", quotient, remainder);
        end
      end
      @(negedge clk);
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL ignore_start_dones got=%0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    int busies;
    dones = 0; busies = 0;
    @(negedge clk);
    a = 8'd100; b = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, quotient, remainder, dz_o, ov_o} !== 20'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%h want=0", {busy, done, quotient, remainder, dz_o, ov_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busies++;
    end
    total++;
    if (dones != 0 || busies != 0) begin
      bad++;
      $display("FAIL reset_mid_abort dones=%0d busy_cycles=%0d want 0 0", dones, busies);
    end
    do_op(8'd7, 8'd2, q, r, dz, ov, lat, bb);
    total++;
    if ({q, r} !== {8'd3, 8'd1} || lat != 9 || bb) begin
      bad++;
      $display("FAIL after_reset_op q=%0d r=%0d lat=%0d want 3 1 9", q, r, lat);
    end
  endtask

  task automatic test_back_to_back;
    int t [$];
    @(negedge clk);
    a = 8'h9C; b = 8'd7; start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) begin
        t.push_back(i);
        total++;
        if (quotient !== 8'hF2 || remainder !== 8'hFE) begin
          bad++;
          $display("FAIL b2b_result q=%h r=%h want f2 fe", quotient, remainder);
        end
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (t.size() < 4) begin
      bad++;
      $display("FAIL b2b_count got=%0d want>=4", t.size());
    end else if (t[0] != 9 || t[1] - t[0] != 10 || t[2] - t[1] != 10 || t[3] - t[2] != 10) begin
      bad++;
      $display("FAIL b2b_spacing first=%0d gaps=%0d,%0d,%0d want 9 10,10,10", t[0], t[1] - t[0], t[2] - t[1], t[3] - t[2]);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] bl [12];
    logic [7:0] av;
    logic [7:0] eq;
    logic [7:0] er;
    logic [7:0] inv;
    logic       eo;
    int ai, bi, qi, ri;
    bl = '{8'd1, 8'hFF, 8'd2, 8'hFE, 8'd3, 8'hFD, 8'd7, 8'hF9, 8'd10, 8'd127, 8'h81, 8'h80};
    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < 256; i++) begin
        av = 8'(i);
        ai = int'($signed(av));
        bi = int'($signed(bl[j]));
        qi = ai / bi;
        ri = ai % bi;
        eq = 8'(qi);
        er = 8'(ri);
        eo = qi > 127;
        do_op(av, bl[j], q, r, dz, ov, lat, bb);
        total++;
        if (q !== eq || r !== er || ov !== eo || dz !== 1'b0 || lat != 9 || bb) begin
          bad++;
          $display("FAIL sweep a=%0d b=%0d q=%h r=%h ov=%b dz=%b lat=%0d bb=%b want %h %h %b 0 9 0", ai, bi, q, r, ov, dz, lat, bb, eq, er, eo);
        end
        inv = q * bl[j] + r;
        total++;
        if (inv !== av) begin
          bad++;
          $display("FAIL invariant a=%h b=%h q*b+r=%h want %h", av, bl[j], inv, av);
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset;
    test_basic;
    test_overflow;
    test_div_zero;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
